// File: rtl/count_run_controller_if.sv
// count_run_controller_if: button, step and datapath handshake bundle for the count run controller.
interface count_run_controller_if;
    logic       start_btn;
    logic       stop_btn;
    logic [1:0] step_sel;
    logic [7:0] count_in;
    logic       cnt_inc;
    logic       cnt_clr;
    logic [3:0] step;
    logic [1:0] state;
    logic       done;
    modport master (
        output start_btn, stop_btn, step_sel, count_in,
        input  cnt_inc, cnt_clr, step, state, done
    );
    modport slave (
        input  start_btn, stop_btn, step_sel, count_in,
        output cnt_inc, cnt_clr, step, state, done
    );
endinterface

// File: rtl/count_run_controller.sv
// count_run_controller: debounced start/stop sequencing of the auto-incrementing count datapath.
// Define AUTO_RESTART_EN to re-enter RUN instead of IDLE when the DONE hold expires.
module count_run_controller #(
    parameter int TICK_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_COUNT       = 150,
    parameter int DONE_HOLD       = 3
) (
    input logic clk_i,
    input logic reset_i,
    count_run_controller_if.slave bus
);
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_e;
`ifdef AUTO_RESTART_EN
    localparam state_e DONE_EXIT = RUN;
`else
    localparam state_e DONE_EXIT = IDLE;
`endif
    state_e               state_q, state_d;
    logic [1:0]           sync1_q, sync2_q, db_q, db_prev_q;
    logic [1:0][DW-1:0]   deb_q;
    logic [TW-1:0]        div_q, div_d;
    logic [3:0]           hold_q, hold_d, step_q, step_d;
    logic                 inc_q, inc_d, clr_q, clr_d, done_q;
    logic                 start_p, stop_p, running, tick, over, hold_last, zero_div;
    assign start_p   = db_q[0] & ~db_prev_q[0];
    assign stop_p    = db_q[1] & ~db_prev_q[1];
    assign running   = state_q == RUN || state_q == DONE;
    assign tick      = running && div_q == TW'(TICK_CYCLES - 1);
    assign over      = {1'b0, bus.count_in} + {5'b0, step_q} > 9'(MAX_COUNT);
    assign hold_last = hold_q == 4'(DONE_HOLD - 1);
    // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            deb_q     <= '0;
        end else begin
            sync1_q   <= {bus.stop_btn, bus.start_btn};
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i] <= '0;
                    db_q[i]  <= sync2_q[i];
                end else begin
                    deb_q[i] <= deb_q[i] + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            hold_q  <= '0;
            step_q  <= 4'd1;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
            done_q  <= state_d == DONE;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_p && !stop_p) state_d = RUN;
            RUN:     if (stop_p) state_d = PAUSE; else if (tick && over) state_d = DONE;
            PAUSE:   if (stop_p) state_d = IDLE; else if (start_p) state_d = RUN;
            DONE:    if (start_p || stop_p) state_d = IDLE; else if (tick && hold_last) state_d = DONE_EXIT;
            default: state_d = IDLE;
        endcase
    end
    // Every fresh run and every return to IDLE clears the datapath; resuming from PAUSE does not.
    always_comb begin
        clr_d    = state_d != state_q && (state_d == IDLE || (state_d == RUN && state_q != PAUSE));
        inc_d    = state_q == RUN && state_d == RUN && tick;
        zero_div = clr_d || (state_q == RUN && state_d == DONE);
        div_d    = zero_div || tick ? '0 : running ? div_q + 1'b1 : div_q;
        hold_d   = state_q != DONE ? 4'd0 : hold_q + {3'b0, tick};
        step_d   = state_q == IDLE && state_d == RUN ? 4'b1 << bus.step_sel : step_q;
    end
    assign bus.cnt_inc = inc_q;
    assign bus.cnt_clr = clr_q;
    assign bus.step    = step_q;
    assign bus.state   = state_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_count_run_controller.sv
// tb_count_run_controller: scoreboard bench with a datapath counter model and expected pulse queue.
module tb_count_run_controller;
    localparam int T = 10, D = 4, MAXC = 150, HOLD = 3;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    count_run_controller_if bus ();
    count_run_controller #(
        .TICK_CYCLES(T), .DEBOUNCE_CYCLES(D), .MAX_COUNT(MAXC), .DONE_HOLD(HOLD)
    ) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus)
    );
    logic [7:0] count;
    always_ff @(posedge clk) count <= rst || bus.cnt_clr ? 8'd0 : bus.cnt_inc ? count + 8'(bus.step) : count;
    assign bus.count_in = count;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_cmp = 0;
    int n_fail = 0;
    typedef struct {bit clr; logic [1:0] st; logic [3:0] stp; int gap;} ev_t;
    ev_t q[$];
    ev_t e;
    int last_evt = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic push(input bit c, input logic [1:0] st, input logic [3:0] stp, input int gap);
        q.push_back('{c, st, stp, gap});
    endtask
    always @(negedge clk) begin
        if (!rst && (bus.cnt_inc || bus.cnt_clr)) begin
            check("inc_clr_exclusive", {31'b0, bus.cnt_inc & bus.cnt_clr}, 0);
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: got inc=%0d clr=%0d, expected no pulse (cycle %0d)",
                         bus.cnt_inc, bus.cnt_clr, cyc);
            end else begin
                e = q.pop_front();
                check(e.clr ? "clr_pulse" : "inc_pulse", {31'b0, bus.cnt_clr}, {31'b0, e.clr});
                check("pulse_state", {30'b0, bus.state}, {30'b0, e.st});
                check("pulse_step", {28'b0, bus.step}, {28'b0, e.stp});
                if (e.gap > 0) check("pulse_gap", cyc - last_evt, e.gap);
            end
            last_evt = cyc;
        end
    end
    task automatic press(input bit s, input bit p);
        bus.start_btn = s;
        bus.stop_btn  = p;
        repeat (10) @(negedge clk);
        bus.start_btn = 1'b0;
        bus.stop_btn  = 1'b0;
        repeat (10) @(negedge clk);
    endtask
    task automatic wait_state(input logic [1:0] s, input int budget, input string nm, output int at);
        int n = 0;
        while (bus.state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        check(nm, {30'b0, bus.state}, {30'b0, s});
    endtask
    task automatic wait_count(input logic [7:0] v, input int budget, input string nm, output int at);
        int n = 0;
        while (count !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        check(nm, {24'b0, count}, {24'b0, v});
    endtask
    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("queue_drained", q.size(), 0);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask
    // Expected pulses come from the counting rule: add step while the result stays within MAXC.
    task automatic run_to_done(input int sel);
        logic [3:0] s;
        int c, at;
        s = 4'b1 << sel;
        c = 0;
        bus.step_sel = sel[1:0];
        push(1'b1, S_RUN, s, 0);
        while (c + s <= MAXC) begin
            c += s;
            push(1'b0, S_RUN, s, T);
        end
`ifdef AUTO_RESTART_EN
        push(1'b1, S_RUN, s, (HOLD + 1) * T);
        push(1'b0, S_RUN, s, T);
`else
        push(1'b1, S_IDLE, s, (HOLD + 1) * T);
`endif
        press(1'b1, 1'b0);
        bus.step_sel = 2'($urandom);
        wait_state(S_DONE, 2000, "reach_done", at);
        check("done_flag", {31'b0, bus.done}, 1);
        check("final_count", {24'b0, count}, c);
        wait_drain((HOLD + 2) * T);
`ifdef AUTO_RESTART_EN
        check("restart_state", {30'b0, bus.state}, {30'b0, S_RUN});
        check("restart_count", {24'b0, count}, {28'b0, s});
        do_reset();
`else
        check("exit_state", {30'b0, bus.state}, {30'b0, S_IDLE});
        check("exit_done", {31'b0, bus.done}, 0);
        check("exit_count", {24'b0, count}, 0);
`endif
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
    initial begin
        int ti, tp, tr, t24, ts, bsel;
        logic [3:0] bs;
        bus.start_btn = 1'b0;
        bus.stop_btn  = 1'b0;
        bus.step_sel  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_state", {30'b0, bus.state}, {30'b0, S_IDLE});
        check("rst_inc", {31'b0, bus.cnt_inc}, 0);
        check("rst_clr", {31'b0, bus.cnt_clr}, 0);
        check("rst_step", {28'b0, bus.step}, 1);
        check("rst_done", {31'b0, bus.done}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_to_done(2);
        // Pause and resume with the divider phase preserved.
        bus.step_sel = 2'd2;
        push(1'b1, S_RUN, 4'd4, 0);
        for (int v = 4; v <= 20; v += 4) push(1'b0, S_RUN, 4'd4, T);
        press(1'b1, 1'b0);
        wait_count(8'd20, 100, "pause_pre_count", ti);
        bus.stop_btn = 1'b1;
        wait_state(S_PAUSE, 20, "pause_enter", tp);
        repeat (10) @(negedge clk);
        bus.stop_btn = 1'b0;
        repeat (100) @(negedge clk);
        check("pause_hold_count", {24'b0, count}, 20);
        check("pause_hold_state", {30'b0, bus.state}, {30'b0, S_PAUSE});
        push(1'b0, S_RUN, 4'd4, 0);
        bus.start_btn = 1'b1;
        wait_state(S_RUN, 20, "resume", tr);
        wait_count(8'd24, 2 * T, "resume_count", t24);
        check("resume_phase", t24 - tr, T - (tp - (ti - 1)) + 1);
        bus.start_btn = 1'b0;
        bus.stop_btn  = 1'b1;
        wait_state(S_PAUSE, 20, "pause_second", tp);
        repeat (10) @(negedge clk);
        bus.stop_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("pause_second_count", {24'b0, count}, 24);
        push(1'b1, S_IDLE, 4'd4, 0);
        press(1'b0, 1'b1);
        wait_state(S_IDLE, 5, "pause_to_idle", tp);
        check("pause_to_idle_count", {24'b0, count}, 0);
        // Bouncing start gives exactly one press.
        bsel = $urandom_range(0, 3);
        bs = 4'b1 << bsel;
        bus.step_sel = bsel[1:0];
        push(1'b1, S_RUN, bs, 0);
        push(1'b0, S_RUN, bs, T);
        push(1'b0, S_RUN, bs, T);
        for (int i = 0; i < 12; i++) begin
            bus.start_btn = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        bus.start_btn = 1'b1;
        ts = cyc;
        wait_state(S_RUN, 20, "bounce_run", tr);
        check("bounce_latency", tr - ts, D + 3);
        repeat (3) @(negedge clk);
        bus.start_btn = 1'b0;
        wait_count(8'(2 * bs), 3 * T, "bounce_count", t24);
        // Coincident start and stop: stop wins in RUN, PAUSE and IDLE.
        bus.start_btn = 1'b1;
        bus.stop_btn  = 1'b1;
        wait_state(S_PAUSE, 20, "pair_in_run", tp);
        repeat (10) @(negedge clk);
        bus.start_btn = 1'b0;
        bus.stop_btn  = 1'b0;
        repeat (10) @(negedge clk);
        push(1'b1, S_IDLE, bs, 0);
        press(1'b1, 1'b1);
        wait_state(S_IDLE, 5, "pair_in_pause", tp);
        press(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("pair_in_idle", {30'b0, bus.state}, {30'b0, S_IDLE});
        check("pair_in_idle_queue", q.size(), 0);
        // Reset mid-run.
        bus.step_sel = 2'd2;
        push(1'b1, S_RUN, 4'd4, 0);
        for (int v = 4; v <= 60; v += 4) push(1'b0, S_RUN, 4'd4, T);
        press(1'b1, 1'b0);
        wait_count(8'd60, 200, "pre_reset_count", ti);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", {30'b0, bus.state}, {30'b0, S_IDLE});
        check("midrst_inc", {31'b0, bus.cnt_inc}, 0);
        check("midrst_clr", {31'b0, bus.cnt_clr}, 0);
        check("midrst_done", {31'b0, bus.done}, 0);
        check("midrst_step", {28'b0, bus.step}, 1);
        rst = 1'b0;
        check("midrst_queue", q.size(), 0);
        repeat (3) @(negedge clk);
        run_to_done(3);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            run_to_done(k == 0 ? 0 : $urandom_range(0, 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/count_run_controller.md
# count_run_controller

Sequencing controller for the auto-incrementing 8-bit count datapath that drives the three-digit display. Debounces the start/stop buttons, generates the 1 s increment tick, and issues single-cycle increment/clear commands to the external counter register. It reads the counter value back to detect the limit, and reports run state and completion to the LED animation.

## Interface
- TICK_CYCLES, 50_000_000: clk cycles per increment tick (1 s at 50 MHz).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required to accept a button level (20 ms).
- MAX_COUNT, 150: upper bound on the count value; 8-bit, 1..255.
- DONE_HOLD, 3: ticks spent in DONE before leaving it; 1..15.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock domain, no other resets.
- start_btn  in  1  raw button level, asynchronous, active-high.
- stop_btn  in  1  raw button level, asynchronous, active-high.
- step_sel  in  2  step select: 00→1, 01→2, 10→4, 11→8.
- count_in  in  8  current datapath count value.
- cnt_inc  out  1  one-cycle pulse; datapath adds `step` to its count.
- cnt_clr  out  1  one-cycle pulse; datapath loads 0. Never asserted together with cnt_inc.
- step  out  4  latched step value, stable except at IDLE→RUN.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- done  out  1  high while in DONE.

## Operation
- Each button passes through a 2-flop synchronizer, then a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples. A rising edge of the debounced level produces a one-cycle press pulse (start_p, stop_p).
- Simultaneous start_p and stop_p in one cycle: stop_p wins; start_p is discarded.
- FSM transitions:
  - IDLE: start_p → RUN. On this transition, latch step from step_sel, assert cnt_clr, and zero the tick divider. stop_p is ignored.
  - RUN: stop_p → PAUSE. On each tick:
    - If count_in + step ≤ MAX_COUNT, pulse cnt_inc.
    - Otherwise go to DONE with no increment, and zero the tick divider.
    - The comparison is 9-bit, so count_in + 8 never wraps.
  - PAUSE: tick divider frozen, holding its value. start_p → RUN, divider resumes. stop_p → IDLE with cnt_clr.
  - DONE: the divider keeps running; count DONE_HOLD ticks. After the last tick, go to IDLE with cnt_clr. start_p or stop_p → IDLE with cnt_clr immediately.
- The tick divider runs only in RUN and DONE. It counts 0..TICK_CYCLES-1, and tick is internal, high for one cycle at the terminal value.
- step_sel changes outside IDLE→RUN have no effect.
- count_in already above MAX_COUNT in RUN: the first tick goes to DONE.

## Timing
- Reset values: state=IDLE, cnt_inc=0, cnt_clr=0, step=1, done=0. Divider, debounce counters and synchronizers are all zeroed.
- Reset asserted mid-operation: all outputs take their reset values at the next edge. No cnt_clr is issued; the datapath shares reset.
- Button latency: raw edge → press pulse in 2 + DEBOUNCE_CYCLES cycles, assuming no bounce.
- Press pulse in cycle N: state and the associated cnt_clr are registered and visible in cycle N+1.
- Tick in cycle N: cnt_inc is high in cycle N+1. The datapath updates at the end of N+1, and count_in is valid from N+2. The next tick is ≥ TICK_CYCLES later, so count_in is always settled at the compare.
- First cnt_inc after IDLE→RUN: TICK_CYCLES cycles after the RUN entry cycle.
- All outputs are registered; no combinational input→output paths.

## Configuration
- AUTO_RESTART_EN defined: when DONE_HOLD expires, go to RUN instead of IDLE. Assert cnt_clr, zero the divider, and keep the latched step. Button presses in DONE still go to IDLE.
- AUTO_RESTART_EN undefined: DONE always exits to IDLE as described above.

## Test plan
Bench parameters: TICK_CYCLES=10, DEBOUNCE_CYCLES=4, MAX_COUNT=150, DONE_HOLD=3. The bench models the datapath counter.
- Start press with step_sel=10 → cnt_clr 1 cycle; cnt_inc every 10 cycles; count 0,4,…,148. The next tick gives DONE with no inc; count stays 148.
- DONE hold → done=1 for 3 ticks, then cnt_clr and IDLE. With AUTO_RESTART_EN: RUN again and count restarts from 4.
- Stop press mid-RUN at count=20 → PAUSE, no cnt_inc for 100 cycles. Start press → RUN; remaining divider phase is preserved. Second stop press → PAUSE; third stop press → IDLE with cnt_clr.
- Bouncing start (toggle every 2 cycles for 12 cycles, then steady high) → exactly one press pulse, 6 cycles after the steady level; exactly one IDLE→RUN.
- Start and stop debounced edges in the same cycle while in RUN → PAUSE. The same pair in IDLE → stays IDLE.
- Reset asserted while in RUN at count=60 → next cycle state=IDLE, cnt_inc=0, done=0, step=1. A later start with step_sel=11 gives increments of 8.
